cluster_pwr_seq: RTL and testbench

CLUSTER_PWR_SEQ -- requirements
Module: cluster_pwr_seq

---
 rtl/cluster_pwr_seq.sv | 164 ++++++++++++++++
 tb/tb_cluster_pwr_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: power switch, clock gate, reset, isolation, fetch.
// Define CLUSTER_PWR_SEQ_TIMEOUT_EN to bound the DRAIN wait and raise err_o.
module cluster_pwr_seq #(
  parameter int unsigned PWR_WAIT = 16,
  parameter int unsigned RST_WAIT = 8,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pwr_on_req_i,
  input  logic        pwr_off_req_i,
  input  logic [63:0] boot_addr_i,
  input  logic        fetch_en_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic [2:0]  state_o,
  output logic        done_evt_o,
  output logic        err_o
);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_PWR_UP  = 3'd1;
  localparam logic [2:0] S_CLK_ON  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_RST     = 3'd5;
  localparam logic [2:0] S_CLK_OFF = 3'd6;
  localparam logic [2:0] S_PWR_DN  = 3'd7;

  // A zero wait still spends one cycle in the state.
  localparam int unsigned PW = (PWR_WAIT == 0) ? 1 : PWR_WAIT;
  localparam int unsigned RW = (RST_WAIT == 0) ? 1 : RST_WAIT;
  localparam int unsigned MW = (PW > RW) ? PW : RW;
  localparam int unsigned CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] PW_LD = CW'(PW - 1);
  localparam logic [CW-1:0] RW_LD = CW'(RW - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic          w_ld;
  logic [CW-1:0] w_ld_val;
  logic          w_tmo_hit;
  logic          r_fe;
  logic          r_done;
  logic [63:0]   r_boot;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam int unsigned TO = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned TW = $clog2(TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO - 1);

  logic [TW-1:0] r_tmo;
  logic          r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo <= '0;
    end else if (r_state == S_DRAIN && cluster_busy_i) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_tmo_hit) begin
      r_err <= 1'b1;
    end else if (r_state == S_OFF && pwr_on_req_i) begin
      r_err <= 1'b0;
    end
  end

  assign w_tmo_hit = (r_state == S_DRAIN) && cluster_busy_i
                     && (r_tmo == TO_LAST);
  assign err_o     = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT == 0);
  assign w_tmo_hit    = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_ld     = 1'b0;
    w_ld_val = '0;
    unique case (r_state)
      S_OFF: begin
        if (pwr_on_req_i) begin
          w_next   = S_PWR_UP;
          w_ld     = 1'b1;
          w_ld_val = PW_LD;
        end
      end
      S_PWR_UP: begin
        if (w_cnt_zero) begin
          w_next   = S_CLK_ON;
          w_ld     = 1'b1;
          w_ld_val = RW_LD;
        end
      end
      S_CLK_ON:  if (w_cnt_zero) w_next = S_RUN;
      S_RUN:     if (pwr_off_req_i) w_next = S_DRAIN;
      S_DRAIN: begin
        if (!cluster_busy_i || w_tmo_hit) w_next = S_RST;
      end
      S_RST:     w_next = S_CLK_OFF;
      S_CLK_OFF: begin
        w_next   = S_PWR_DN;
        w_ld     = 1'b1;
        w_ld_val = PW_LD;
      end
      S_PWR_DN:  if (w_cnt_zero) w_next = S_OFF;
      default:   w_next = S_OFF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_fe    <= 1'b0;
      r_done  <= 1'b0;
      r_boot  <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld) begin
        r_cnt <= w_ld_val;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_fe   <= (w_next == S_RUN) && fetch_en_i;
      r_done <= ((w_next == S_RUN) && (r_state != S_RUN))
             || ((w_next == S_OFF) && (r_state != S_OFF));
      if (r_state == S_OFF && pwr_on_req_i) begin
        r_boot <= boot_addr_i;
      end
    end
  end

  assign state_o                = r_state;
  assign cluster_pow_o          = (r_state != S_OFF)
                                  && (r_state != S_PWR_DN);
  assign cluster_clk_en_o       = (r_state >= S_CLK_ON)
                                  && (r_state <= S_RST);
  assign cluster_rstn_o         = (r_state == S_RUN)
                                  || (r_state == S_DRAIN);
  assign cluster_byp_o          = !cluster_rstn_o;
  assign cluster_fetch_enable_o = r_fe;
  assign cluster_boot_addr_o    = r_boot;
  assign done_evt_o             = r_done;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq with an expected-output queue.
// Outputs are sampled 1 time unit after each rising edge.
module tb_cluster_pwr_seq;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        on_req, off_req, fetch_en, busy;
  logic [63:0] boot_in;
  logic        pow, byp, clk_en, rstn, fe, done, err;
  logic [63:0] boot_out;
  logic [2:0]  st;

  always #5 clk = ~clk;

  cluster_pwr_seq #(
    .PWR_WAIT(16),
    .RST_WAIT(8),
    .TIMEOUT (1024)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .pwr_on_req_i          (on_req),
    .pwr_off_req_i         (off_req),
    .boot_addr_i           (boot_in),
    .fetch_en_i            (fetch_en),
    .cluster_busy_i        (busy),
    .cluster_pow_o         (pow),
    .cluster_byp_o         (byp),
    .cluster_clk_en_o      (clk_en),
    .cluster_rstn_o        (rstn),
    .cluster_fetch_enable_o(fe),
    .cluster_boot_addr_o   (boot_out),
    .state_o               (st),
    .done_evt_o            (done),
    .err_o                 (err)
  );

  typedef struct {
    string       tag;
    logic [9:0]  v;
    logic [63:0] ba;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_ba = '0;
  logic [9:0]  obs;

  assign obs = {st, pow, clk_en, rstn, byp, fe, done, err};

  function automatic logic [9:0] model(
    input logic [2:0] s, input logic f,
    input logic d, input logic e);
    logic p, c, r, b;
    p = (s != 3'd0) && (s != 3'd7);
    c = (s >= 3'd2) && (s <= 3'd5);
    r = (s == 3'd3) || (s == 3'd4);
    b = !r;
    return {s, p, c, r, b, f, d, e};
  endfunction

  task automatic push(input string tag, input logic [2:0] s,
                      input logic f, input logic d,
                      input logic e);
    exp_t x;
    x.tag = tag;
    x.v   = model(s, f, d, e);
    x.ba  = exp_ba;
    sbq.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    n_cmp++;
    assert (sbq.size() > 0) else begin
      n_bad++;
      $error("FAIL scoreboard: queue size %0d, need >0",
             sbq.size());
    end
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      n_cmp++;
      assert (obs === x.v) else begin
        n_bad++;
        $error({"FAIL %s: {st,pow,clk,rstn,byp,fe,done,err}",
                " got %b want %b"}, x.tag, obs, x.v);
      end
      n_cmp++;
      assert (boot_out === x.ba) else begin
        n_bad++;
        $error("FAIL %s boot: got %h want %h",
               x.tag, boot_out, x.ba);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] s,
                      input logic f, input logic d,
                      input logic e);
    push(tag, s, f, d, e);
    tick();
    pop_check();
  endtask

  task automatic now(input string tag, input logic [2:0] s,
                     input logic f, input logic d,
                     input logic e);
    push(tag, s, f, d, e);
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni   = 1'b0;
    on_req   = 1'b0;
    off_req  = 1'b0;
    fetch_en = 1'b0;
    busy     = 1'b0;
    boot_in  = '0;
    #3;
    now("reset", 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    now("idle", 3'd0, 0, 0, 0);

    off_req = 1'b1;
    step("off_in_off", 3'd0, 0, 0, 0);
    off_req = 1'b0;

    on_req   = 1'b1;
    fetch_en = 1'b1;
    boot_in  = 64'h1C00_8080;
    exp_ba   = 64'h1C00_8080;
    step("pu_c1", 3'd1, 0, 0, 0);
    on_req  = 1'b0;
    boot_in = '1;
    repeat (14) tick();
    step("pu_c16", 3'd1, 0, 0, 0);
    step("clkon_c17", 3'd2, 0, 0, 0);
    repeat (6) tick();
    step("clkon_c24", 3'd2, 0, 0, 0);
    step("run_c25", 3'd3, 1, 1, 0);
    step("run_c26", 3'd3, 1, 0, 0);

    on_req = 1'b1;
    step("on_in_run", 3'd3, 1, 0, 0);
    on_req = 1'b0;

    off_req = 1'b1;
    busy    = 1'b1;
    step("drain_1", 3'd4, 0, 0, 0);
    off_req = 1'b0;
    repeat (38) tick();
    step("drain_40", 3'd4, 0, 0, 0);
    busy = 1'b0;
    step("rst_assert", 3'd5, 0, 0, 0);
    step("clk_off", 3'd6, 0, 0, 0);
    step("pd_1", 3'd7, 0, 0, 0);
    repeat (14) tick();
    step("pd_16", 3'd7, 0, 0, 0);
    step("off_done", 3'd0, 0, 1, 0);
    step("off_idle", 3'd0, 0, 0, 0);

    on_req   = 1'b1;
    off_req  = 1'b1;
    fetch_en = 1'b0;
    boot_in  = 64'hDEAD_BEEF_0000_1000;
    exp_ba   = 64'hDEAD_BEEF_0000_1000;
    step("both_req", 3'd1, 0, 0, 0);
    on_req  = 1'b0;
    off_req = 1'b0;
    repeat (15) tick();
    step("clkon2", 3'd2, 0, 0, 0);
    repeat (7) tick();
    step("run2_nofe", 3'd3, 0, 1, 0);
    fetch_en = 1'b1;
    step("fe_follow", 3'd3, 1, 0, 0);

    off_req = 1'b1;
    busy    = 1'b1;
    step("drain2", 3'd4, 0, 0, 0);
    off_req = 1'b0;
    repeat (3) tick();
    #2 rst_ni = 1'b0;
    exp_ba = '0;
    #1;
    now("rst_in_drain", 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    busy   = 1'b0;
    tick();
    now("after_rst1", 3'd0, 0, 0, 0);

    on_req  = 1'b1;
    boot_in = 64'h0000_0000_8000_0000;
    exp_ba  = 64'h0000_0000_8000_0000;
    step("pu3", 3'd1, 0, 0, 0);
    on_req = 1'b0;
    repeat (16) tick();
    repeat (2) tick();
    #2 rst_ni = 1'b0;
    exp_ba = '0;
    #1;
    now("rst_in_clkon", 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    on_req  = 1'b1;
    boot_in = 64'h1C00_8080;
    exp_ba  = 64'h1C00_8080;
    step("resume_pu", 3'd1, 0, 0, 0);
    on_req = 1'b0;
    repeat (23) tick();
    step("run3", 3'd3, 1, 1, 0);

    off_req = 1'b1;
    busy    = 1'b1;
    step("drain3_1", 3'd4, 0, 0, 0);
    off_req = 1'b0;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    repeat (1022) tick();
    step("drain3_1024", 3'd4, 0, 0, 0);
    step("tmo_rst", 3'd5, 0, 0, 1);
    step("tmo_clkoff", 3'd6, 0, 0, 1);
    repeat (16) tick();
    step("tmo_off", 3'd0, 0, 1, 1);
    busy   = 1'b0;
    on_req = 1'b1;
    step("err_clear", 3'd1, 0, 0, 0);
    on_req = 1'b0;
`else
    repeat (1099) tick();
    step("drain_hold", 3'd4, 0, 0, 0);
    busy = 1'b0;
    step("hold_rst", 3'd5, 0, 0, 0);
    step("hold_clkoff", 3'd6, 0, 0, 0);
    repeat (16) tick();
    step("hold_off", 3'd0, 0, 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
